// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI bus arbiter: FSM states, owner
// status codes and the pin bundle with its idle (all deselected) value.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_A    = 2'd1;
  localparam logic [1:0] OWNER_B    = 2'd2;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef struct packed {
    logic [3:0] data_out;
    logic [3:0] data_oe;
    logic       clk_out;
    logic       flash_select;
    logic       ram_a_select;
    logic       ram_b_select;
  } qspi_pins_t;

  localparam logic [3:0] IDLE_DATA   = 4'h0;
  localparam logic [3:0] IDLE_OE     = 4'h0;
  localparam logic       IDLE_CLK    = 1'b0;
  localparam logic       IDLE_SELECT = 1'b1;

  localparam qspi_pins_t PINS_IDLE = '{
    data_out:     IDLE_DATA,
    data_oe:      IDLE_OE,
    clk_out:      IDLE_CLK,
    flash_select: IDLE_SELECT,
    ram_a_select: IDLE_SELECT,
    ram_b_select: IDLE_SELECT
  };

  function automatic logic [1:0] owner_code(arb_state_e s);
    case (s)
      OWN_A:   owner_code = OWNER_A;
      OWN_B:   owner_code = OWNER_B;
      default: owner_code = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter_if.sv
// One requester's connection to the arbiter: handshake, SPI outputs and the
// broadcast SD inputs. master = requester side, slave = arbiter side.
interface qspi_bus_arbiter_if;
  logic       req;
  logic       gnt;
  logic [3:0] data_out;
  logic [3:0] data_oe;
  logic [3:0] data_in;
  logic       clk_out;
  logic       flash_select;
  logic       ram_a_select;
  logic       ram_b_select;

  modport master (
    output req, data_out, data_oe, clk_out, flash_select, ram_a_select, ram_b_select,
    input  gnt, data_in
  );

  modport slave (
    input  req, data_out, data_oe, clk_out, flash_select, ram_a_select, ram_b_select,
    output gnt, data_in
  );
endinterface

// File: rtl/qspi_pin_mux.sv
// Combinational pad mux: passes the owning requester's pins through, or the
// idle values when nobody owns the bus or reset is asserted.
module qspi_pin_mux
  import qspi_arb_pkg::*;
(
  input  logic       rst,
  input  arb_state_e state,
  input  qspi_pins_t a_pins,
  input  qspi_pins_t b_pins,
  output qspi_pins_t pad_pins
);

  // rst overrides the state so pins are idle even before the state reinitialises
  always_comb begin
    pad_pins = PINS_IDLE;
    if (rst) begin
      pad_pins = PINS_IDLE;
    end else begin
      case (state)
        OWN_A:     pad_pins = a_pins;
        OWN_B:     pad_pins = b_pins;
        IDLE, GAP: pad_pins = PINS_IDLE;
        default:   pad_pins = PINS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-requester QSPI pin arbiter. Ownership changes only when the owner is
// idle and has dropped req, followed by GAP_CYCLES of idle pins.
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int GAP_CYCLES    = 2,
  parameter int A_RESET_OWNER = 1
) (
  input  logic               clk,
  input  logic               rst,
  qspi_bus_arbiter_if.slave  a,
  qspi_bus_arbiter_if.slave  b,
  input  logic [3:0]         qspi_data_in,
  output logic [3:0]         qspi_data_out,
  output logic [3:0]         qspi_data_oe,
  output logic               qspi_clk_out,
  output logic               qspi_flash_select,
  output logic               qspi_ram_a_select,
  output logic               qspi_ram_b_select,
  output logic [1:0]         owner
);

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);
  localparam arb_state_e RESET_STATE = (A_RESET_OWNER != 0) ? OWN_A : IDLE;

  arb_state_e state_r, next_state_s, pick_s;
  logic [3:0] gap_cnt_r, next_gap_cnt_s;
  logic       last_owner_r, next_last_owner_s;
  logic       a_idle_s, b_idle_s;
  qspi_pins_t a_pins_s, b_pins_s, pad_pins_s;

  assign a_idle_s = a.flash_select & a.ram_a_select & a.ram_b_select;
  assign b_idle_s = b.flash_select & b.ram_a_select & b.ram_b_select;

  // On a tie the requester that did not own the bus last wins
  always_comb begin
    pick_s = IDLE;
    if (a.req && b.req) begin
      if (last_owner_r == LAST_B) begin
        pick_s = OWN_A;
      end else begin
        pick_s = OWN_B;
      end
    end else if (a.req) begin
      pick_s = OWN_A;
    end else if (b.req) begin
      pick_s = OWN_B;
    end else begin
      pick_s = IDLE;
    end
  end

  // Next-state logic; an owner is released only between transactions
  always_comb begin
    next_state_s      = state_r;
    next_gap_cnt_s    = gap_cnt_r;
    next_last_owner_s = last_owner_r;
    case (state_r)
      IDLE: next_state_s = pick_s;
      OWN_A: begin
        if (!a.req && a_idle_s) begin
          next_state_s      = GAP;
          next_gap_cnt_s    = GAP_INIT;
          next_last_owner_s = LAST_A;
        end else begin
          next_state_s = OWN_A;
        end
      end
      OWN_B: begin
        if (!b.req && b_idle_s) begin
          next_state_s      = GAP;
          next_gap_cnt_s    = GAP_INIT;
          next_last_owner_s = LAST_B;
        end else begin
          next_state_s = OWN_B;
        end
      end
      GAP: begin
        if (gap_cnt_r == 4'd0) begin
          next_state_s = pick_s;
        end else begin
          next_gap_cnt_s = gap_cnt_r - 4'd1;
        end
      end
      default: next_state_s = RESET_STATE;
    endcase
  end

  // State, gap counter and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RESET_STATE;
      gap_cnt_r    <= 4'd0;
      last_owner_r <= LAST_B;
    end else begin
      state_r      <= next_state_s;
      gap_cnt_r    <= next_gap_cnt_s;
      last_owner_r <= next_last_owner_s;
    end
  end

  assign a.gnt     = (state_r == OWN_A);
  assign b.gnt     = (state_r == OWN_B);
  assign owner     = owner_code(state_r);
  assign a.data_in = qspi_data_in;
  assign b.data_in = qspi_data_in;

  assign a_pins_s = '{
    data_out: a.data_out, data_oe: a.data_oe, clk_out: a.clk_out,
    flash_select: a.flash_select, ram_a_select: a.ram_a_select, ram_b_select: a.ram_b_select
  };
  assign b_pins_s = '{
    data_out: b.data_out, data_oe: b.data_oe, clk_out: b.clk_out,
    flash_select: b.flash_select, ram_a_select: b.ram_a_select, ram_b_select: b.ram_b_select
  };

  qspi_pin_mux u_pin_mux (
    .rst      (rst),
    .state    (state_r),
    .a_pins   (a_pins_s),
    .b_pins   (b_pins_s),
    .pad_pins (pad_pins_s)
  );

  assign qspi_data_out     = pad_pins_s.data_out;
  assign qspi_data_oe      = pad_pins_s.data_oe;
  assign qspi_clk_out      = pad_pins_s.clk_out;
  assign qspi_flash_select = pad_pins_s.flash_select;
  assign qspi_ram_a_select = pad_pins_s.ram_a_select;
  assign qspi_ram_b_select = pad_pins_s.ram_b_select;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Randomized bench for qspi_bus_arbiter against an owner/gap-countdown model
// derived from the arbitration rules.
module tb_qspi_bus_arbiter;

  localparam int GAP = 2;
  localparam logic [10:0] IDLE_PADS = {4'h0, 4'h0, 1'b0, 3'b111};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] qspi_data_in, qspi_data_out, qspi_data_oe;
  logic       qspi_clk_out, qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select;
  logic [1:0] owner;

  always #5 clk = ~clk;

  qspi_bus_arbiter_if a_if ();
  qspi_bus_arbiter_if b_if ();

  qspi_bus_arbiter #(.GAP_CYCLES(GAP), .A_RESET_OWNER(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .a                 (a_if),
    .b                 (b_if),
    .qspi_data_in      (qspi_data_in),
    .qspi_data_out     (qspi_data_out),
    .qspi_data_oe      (qspi_data_oe),
    .qspi_clk_out      (qspi_clk_out),
    .qspi_flash_select (qspi_flash_select),
    .qspi_ram_a_select (qspi_ram_a_select),
    .qspi_ram_b_select (qspi_ram_b_select),
    .owner             (owner)
  );

  int n_vec = 0;
  int n_mis = 0;

  // model: current owner (0 none, 1 A, 2 B), gap cycles remaining, last owner
  int m_owner = 1;
  int m_gap_left = 0;
  int m_last = 2;
  int txn_left[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (a_if.req && b_if.req) return (m_last == 1) ? 2 : 1;
    if (a_if.req) return 1;
    if (b_if.req) return 2;
    return 0;
  endfunction

  task automatic model_step();
    bit a_quiet, b_quiet;
    a_quiet = a_if.flash_select && a_if.ram_a_select && a_if.ram_b_select;
    b_quiet = b_if.flash_select && b_if.ram_a_select && b_if.ram_b_select;
    if (rst) begin
      m_owner = 1; m_gap_left = 0; m_last = 2;
    end else if (m_owner == 1) begin
      if (!a_if.req && a_quiet) begin m_owner = 0; m_gap_left = GAP; m_last = 1; end
    end else if (m_owner == 2) begin
      if (!b_if.req && b_quiet) begin m_owner = 0; m_gap_left = GAP; m_last = 2; end
    end else if (m_gap_left > 1) begin
      m_gap_left--;
    end else begin
      m_owner = model_pick();
      m_gap_left = 0;
    end
  endtask

  function automatic logic [10:0] pins_of(input int who);
    if (who == 1)
      return {a_if.data_out, a_if.data_oe, a_if.clk_out,
              a_if.flash_select, a_if.ram_a_select, a_if.ram_b_select};
    return {b_if.data_out, b_if.data_oe, b_if.clk_out,
            b_if.flash_select, b_if.ram_a_select, b_if.ram_b_select};
  endfunction

  // A requester obeying the contract: selects low only while granted
  task automatic gen_req(input int idx, input bit gnt, input int req_pct,
                         output logic req, output logic [2:0] sel);
    logic [2:0] one;
    sel = 3'b111;
    one = 3'b001;
    if (!gnt) txn_left[idx] = 0;
    else if (txn_left[idx] == 0 && $urandom_range(0, 2) == 0) txn_left[idx] = $urandom_range(1, 6);
    if (txn_left[idx] > 0) begin
      sel = ~(one << $urandom_range(0, 2));
      txn_left[idx]--;
      req = 1'($urandom_range(0, 1));
    end else begin
      req = ($urandom_range(0, 99) < req_pct);
    end
  endtask

  initial begin
    logic       rq;
    logic [2:0] sl;
    int         pct;
    logic [10:0] pads;
    txn_left[0] = 0;
    txn_left[1] = 0;
    rst = 1'b1;
    qspi_data_in = 4'h0;
    a_if.req = 1'b1; a_if.data_out = 4'h5; a_if.data_oe = 4'hf; a_if.clk_out = 1'b1;
    {a_if.flash_select, a_if.ram_a_select, a_if.ram_b_select} = 3'b011;
    b_if.req = 1'b0; b_if.data_out = 4'ha; b_if.data_oe = 4'hf; b_if.clk_out = 1'b1;
    {b_if.flash_select, b_if.ram_a_select, b_if.ram_b_select} = 3'b111;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      check_eq("a_gnt", a_if.gnt, (m_owner == 1));
      check_eq("b_gnt", b_if.gnt, (m_owner == 2));
      check_eq("owner", owner, m_owner);

      if (cyc < 3) begin
        // hold A mid-transaction (flash CS low, SCK high) through reset
        rst = 1'b1;
      end else begin
        rst = (cyc > 10) && ($urandom_range(0, 299) == 0);
        pct = (cyc < 1500) ? 80 : (cyc < 3000) ? 10 : 50;
        if (rst) begin
          txn_left[0] = 0;
          txn_left[1] = 0;
        end
        gen_req(0, !rst && (m_owner == 1), pct, rq, sl);
        a_if.req = rq;
        {a_if.flash_select, a_if.ram_a_select, a_if.ram_b_select} = sl;
        gen_req(1, !rst && (m_owner == 2), pct, rq, sl);
        b_if.req = rq;
        {b_if.flash_select, b_if.ram_a_select, b_if.ram_b_select} = sl;
        a_if.data_out = 4'($urandom); a_if.data_oe = 4'($urandom); a_if.clk_out = 1'($urandom);
        b_if.data_out = 4'($urandom); b_if.data_oe = 4'($urandom); b_if.clk_out = 1'($urandom);
      end
      qspi_data_in = 4'($urandom);
      #1;
      pads = {qspi_data_out, qspi_data_oe, qspi_clk_out,
              qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select};
      check_eq("pads", pads, (rst || m_owner == 0) ? IDLE_PADS : pins_of(m_owner));
      check_eq("a_data_in", a_if.data_in, qspi_data_in);
      check_eq("b_data_in", b_if.data_in, qspi_data_in);
      if (cyc < 3) begin
        check_eq("rst_flash_cs", qspi_flash_select, 1'b1);
        check_eq("rst_sck", qspi_clk_out, 1'b0);
        check_eq("rst_oe", qspi_data_oe, 4'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
- Shares the single QSPI pin set (flash CS, RAM A/B CS, SCK, SD[3:0]) between two requesters.
- Requester A is the tinyQV memory controller. Requester B is an auxiliary master, such as a flash loader or DMA engine.
- Sits between the requesters' spi_* signals and the SB_IO pad instances.
- Guarantees that ownership changes only while the bus is idle, followed by a fixed turnaround gap.

Parameters:
- GAP_CYCLES, default 2: cycles with all selects high, SCK low and OE off between owners. Legal range 1..15.
- A_RESET_OWNER, default 1: 1 means A owns the bus directly out of reset (CPU boots from flash). 0 means the arbiter leaves reset in IDLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- a_req  in  1  requester A wants the bus.
- a_gnt  out  1  A owns the bus.
- a_data_out  in  4  A's SD outputs.
- a_data_oe  in  4  A's SD output enables.
- a_clk_out  in  1  A's SCK.
- a_flash_select  in  1  A's flash CS, active-low.
- a_ram_a_select  in  1  A's RAM A CS, active-low.
- a_ram_b_select  in  1  A's RAM B CS, active-low.
- b_req, b_gnt, b_data_out, b_data_oe, b_clk_out, b_flash_select, b_ram_a_select, b_ram_b_select: same as A, for requester B.
- qspi_data_in  in  4  pad SD inputs.
- a_data_in  out  4  SD inputs to A.
- b_data_in  out  4  SD inputs to B.
- qspi_data_out  out  4  to pads.
- qspi_data_oe  out  4  to pads.
- qspi_clk_out  out  1  to pads.
- qspi_flash_select  out  1  to pads.
- qspi_ram_a_select  out  1  to pads.
- qspi_ram_b_select  out  1  to pads.
- owner  out  2  status: 0 none/gap, 1 A, 2 B.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State register, four states:
  - IDLE: no owner.
  - OWN_A, OWN_B: that requester owns the bus.
  - GAP: turnaround, with a down-counter gap_cnt of width 4.
- Reset:
  - State goes to OWN_A if A_RESET_OWNER=1, otherwise IDLE.
  - gap_cnt goes to 0 and last_owner goes to B, so A wins the first tie.
  - While rst is high, pad outputs are forced idle combinationally, regardless of state: selects 1, SCK 0, OE 0, data_out 0.
- Pad outputs are a combinational mux on the registered state, with zero added latency.
  - OWN_A passes A's signals through unchanged. OWN_B passes B's signals through unchanged.
  - IDLE and GAP drive the idle values.
- qspi_data_in is broadcast to a_data_in and b_data_in in every state. Data is meaningful only to the owner.
- Grants: a_gnt = (state==OWN_A), b_gnt = (state==OWN_B). owner is encoded from state. All are registered-state decodes with no glitches.
- "Owner idle" means the owner's flash_select, ram_a_select and ram_b_select are all 1 in the current cycle.
- OWN_X transitions:
  - Leaves only when x_req==0 and owner idle. Next state is GAP with gap_cnt=GAP_CYCLES-1, and last_owner is set to X.
  - If x_req drops while any of X's selects is low, ownership is held until the selects are all high. A transaction is never truncated.
  - The other requester's req has no effect while X owns the bus. There is no preemption.
- GAP transitions:
  - Decrements gap_cnt each cycle.
  - When gap_cnt==0, evaluates the requests in that same cycle:
    - Both requesting: grant the one that is not last_owner (round-robin).
    - One requesting: grant it.
    - None requesting: go to IDLE.
  - Minimum idle time between owners is GAP_CYCLES cycles.
- IDLE transitions:
  - Any request is granted on the next edge, using the same tie rule.
  - There is no gap from IDLE, because the pins are already idle.
- Grant latency:
  - From IDLE: req high at edge n gives gnt high after edge n+1.
  - From release: the owner's release edge, then GAP_CYCLES gap cycles, then the new gnt.
- Requester contract:
  - A requester must drive its selects high whenever x_gnt==0.
  - A requester must not start a transaction until it sees x_gnt==1.
  - The arbiter does not check this. Non-owner signals are simply ignored.
- Reset mid-transaction: pins go idle during the rst cycle and the state is reinitialised. Requesters are reset by the same rst.

Decomposition:
- Package qspi_arb_pkg holds:
  - the state enum: IDLE, OWN_A, OWN_B, GAP;
  - owner codes: OWNER_NONE=0, OWNER_A=1, OWNER_B=2;
  - the idle pin-value constants.
- One natural sub-module, qspi_pin_mux: purely combinational selection of one of the two pin bundles or the idle values, given state and rst.
- FSM and gap counter live in the top module.

Test Plan:
- Reset, A_RESET_OWNER=1, GAP_CYCLES=2:
  - During rst, drive a_flash_select=0 and a_clk_out=1. Pads must read flash CS=1, SCK=0, OE=0.
  - After rst falls: a_gnt=1, owner=1, and pads follow A the same cycle.
- Handover A→B:
  - A holds selects high and drops a_req at edge n while b_req=1.
  - State is GAP on edges n+1..n+2 with owner=0 and pads idle.
  - b_gnt=1 and owner=2 from edge n+3.
  - a_gnt=0 from edge n+1.
- Release mid-transaction:
  - A drops a_req while a_ram_a_select=0 for 5 cycles.
  - a_gnt stays 1 and pads still mirror A.
  - GAP begins the edge after ram_a_select returns to 1.
- Round-robin:
  - B releases with a_req=b_req=1 throughout. A is granted after the gap.
  - A then releases. B is granted.
  - No requester is granted twice in a row while the other waits.
- No-preempt and IDLE path:
  - Both requests low after a release: state goes GAP then IDLE, owner=0.
  - b_req is raised at edge m: b_gnt=1 after edge m+1, with no gap.
  - While B owns the bus, a_req=1 for 20 cycles has no effect.
